mac_feeder: RTL and testbench
=============================

MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the operand/result width (IEEE-754 single).
REQ-002 Parameter KERNEL_SIZE, default 9, SHALL set the number of data/weight pairs per dot product (range 1..256).
REQ-003 Parameter MAC_LATENCY, default 4, SHALL set the number of cycles from operand drive to a valid MAC result (range 1..15).
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- multAddRst  in  1  reset, asynchronous, active-high
- start  in  1  begin one dot product (single-cycle pulse)
- bias  in  DATA_WIDTH  initial accumulator value, sampled on accepted start
- inValid  in  1  data/weight pair valid
- inReady  out  1  feeder accepts pair this cycle
- inData  in  DATA_WIDTH  feature-map element
- inWeight  in  DATA_WIDTH  kernel weight
- macData  out  DATA_WIDTH  to MAC data operand
- macWeight  out  DATA_WIDTH  to MAC weight operand
- macSum  out  DATA_WIDTH  to MAC sum operand (running accumulator)
- macResult  in  DATA_WIDTH  MAC result (data*weight+sum)
- outValid  out  1  dot-product result valid
- outResult  out  DATA_WIDTH  final accumulated result
- outReady  in  1  downstream accepts result
- busy  out  1  high in every state except IDLE

Function
REQ-005 FSM states SHALL be IDLE, LOAD, WAIT, DONE.
REQ-006 IDLE: start=1 -> acc<=bias, elemCnt<=0, go LOAD; start SHALL be ignored in all other states.
REQ-007 LOAD: inReady=1 (combinational from state); on inValid&inReady, macData<=inData, macWeight<=inWeight, macSum<=acc, waitCnt<=MAC_LATENCY-1, go WAIT.
REQ-008 inReady SHALL be 0 in IDLE, WAIT, DONE; no pair SHALL be consumed outside LOAD.
REQ-009 macData/macWeight/macSum SHALL hold stable from the LOAD-exit edge until the next pair is loaded.
REQ-010 WAIT: waitCnt decrements each cycle; at the edge where waitCnt==0 (MAC_LATENCY cycles after operand drive), acc<=macResult.
REQ-011 At that same edge: if elemCnt==KERNEL_SIZE-1 -> outResult<=macResult, outValid<=1, go DONE; else elemCnt<=elemCnt+1, go LOAD.
REQ-012 Throughput SHALL be one pair per MAC_LATENCY+1 cycles with inValid held high; total start-to-outValid latency = 1 + KERNEL_SIZE*(MAC_LATENCY+1) cycles.
REQ-013 DONE: outValid and outResult SHALL hold until outValid&outReady, then outValid<=0, go IDLE; a start in that same cycle SHALL be ignored.
REQ-014 KERNEL_SIZE=1: a single pair SHALL produce outValid with result = macResult of that pair.
REQ-015 The feeder SHALL perform no arithmetic on operand values; acc is a plain register.
REQ-016 elemCnt width SHALL be clog2(KERNEL_SIZE)+1; waitCnt width 4 bits.

Reset
REQ-017 multAddRst=1 SHALL asynchronously force state IDLE and acc, elemCnt, waitCnt, macData, macWeight, macSum, outResult to 0, and outValid, inReady, busy to 0.
REQ-018 Reset asserted mid-operation SHALL abandon the dot product with no outValid; the first start after deassertion SHALL begin a fresh computation.

Verification
REQ-019 Bench SHALL model the MAC as an integer d*w+s with MAC_LATENCY-cycle delay and cover:
- KERNEL_SIZE=9, bias=5, inData=0..8, inWeight=2, inValid held -> outValid after 1+9*5=46 cycles, outResult=77.
- inValid low for 3 cycles in LOAD between pairs 4 and 5 -> inReady stays 1, result unchanged (77), outValid delayed by 3 cycles.
- outReady held low 10 cycles after outValid -> outValid/outResult stable for 10 cycles, IDLE one cycle after outReady=1.
- start pulsed during WAIT and during DONE -> ignored; bias not resampled; result 77.
- multAddRst pulsed after pair 3 -> all outputs 0 immediately, no outValid; new start with bias=0, data=1, weight=1 -> outResult=9.
- KERNEL_SIZE=1, bias=3, data=4, weight=5 -> outResult=23 after 1+MAC_LATENCY+1 cycles.

Source files
------------

// File: rtl/mac_feeder_if.sv
// mac_feeder_if: operand stream in, MAC operand/result bus, result stream out.
// master = producer/MAC/consumer side, slave = mac_feeder.
interface mac_feeder_if #(
  parameter int DW = 32
);
  logic          start;
  logic [DW-1:0] bias;
  logic          inValid;
  logic          inReady;
  logic [DW-1:0] inData;
  logic [DW-1:0] inWeight;
  logic [DW-1:0] macData;
  logic [DW-1:0] macWeight;
  logic [DW-1:0] macSum;
  logic [DW-1:0] macResult;
  logic          outValid;
  logic [DW-1:0] outResult;
  logic          outReady;
  logic          busy;

  modport master (
    output start,
    output bias,
    output inValid,
    output inData,
    output inWeight,
    output macResult,
    output outReady,
    input  inReady,
    input  macData,
    input  macWeight,
    input  macSum,
    input  outValid,
    input  outResult,
    input  busy
  );

  modport slave (
    input  start,
    input  bias,
    input  inValid,
    input  inData,
    input  inWeight,
    input  macResult,
    input  outReady,
    output inReady,
    output macData,
    output macWeight,
    output macSum,
    output outValid,
    output outResult,
    output busy
  );
endinterface

// File: rtl/mac_feeder.sv
// mac_feeder: sequences KERNEL_SIZE data/weight pairs through an external
// MAC, feeding the running sum back; ports: clk, multAddRst, bus (slave).
module mac_feeder #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 9,
  parameter int MAC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        multAddRst,
  mac_feeder_if.slave bus
);

  localparam int CW = $clog2(KERNEL_SIZE) + 1;
  localparam logic [CW-1:0] LAST = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [3:0]    WLAT = 4'(MAC_LATENCY - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_t;

  state_t        state_q, state_d;
  word_t         acc_q, acc_d;
  word_t         dat_q, dat_d;
  word_t         wgt_q, wgt_d;
  word_t         sum_q, sum_d;
  word_t         res_q, res_d;
  logic [CW-1:0] elem_q, elem_d;
  logic [3:0]    wait_q, wait_d;
  logic          vld_q, vld_d;

  always_ff @(posedge clk or posedge multAddRst) begin
    if (multAddRst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dat_q   <= '0;
      wgt_q   <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      elem_q  <= '0;
      wait_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dat_q   <= dat_d;
      wgt_q   <= wgt_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      elem_q  <= elem_d;
      wait_q  <= wait_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dat_d   = dat_q;
    wgt_d   = wgt_q;
    sum_d   = sum_q;
    res_d   = res_q;
    elem_d  = elem_q;
    wait_d  = wait_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.bias;
          elem_d  = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // inReady is 1 for the whole state
        if (bus.inValid) begin
          dat_d   = bus.inData;
          wgt_d   = bus.inWeight;
          sum_d   = acc_q;
          wait_d  = WLAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          // MAC output is valid on this edge
          acc_d = bus.macResult;
          if (elem_q == LAST) begin
            res_d   = bus.macResult;
            vld_d   = 1'b1;
            state_d = DONE;
          end else begin
            elem_d  = elem_q + ONE;
            state_d = LOAD;
          end
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      DONE: begin
        if (bus.outReady) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inReady   = (state_q == LOAD);
  assign bus.busy      = (state_q != IDLE);
  assign bus.macData   = dat_q;
  assign bus.macWeight = wgt_q;
  assign bus.macSum    = sum_q;
  assign bus.outValid  = vld_q;
  assign bus.outResult = res_q;

endmodule

// File: tb/tb_mac_feeder.sv
// tb_mac_feeder: random + directed stimulus, integer MAC model,
// queue scoreboard with separate output monitors.
module tb_mac_feeder;

  localparam int DW = 32;
  localparam int L  = 4;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          stall;
    int          t0;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mac_feeder_if #(.DW(DW)) ifa ();
  mac_feeder_if #(.DW(DW)) ifb ();

  mac_feeder #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(9),
    .MAC_LATENCY(L)
  ) u_a (
    .clk       (clk),
    .multAddRst(rst),
    .bus       (ifa)
  );

  mac_feeder #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(1),
    .MAC_LATENCY(L)
  ) u_b (
    .clk       (clk),
    .multAddRst(rst),
    .bus       (ifb)
  );

  // MAC model: d*w+s, visible L edges after the operands change
  logic [DW-1:0] pa [L-1];
  logic [DW-1:0] pb [L-1];

  always @(posedge clk) begin
    pa[0] <= ifa.macData * ifa.macWeight + ifa.macSum;
    pb[0] <= ifb.macData * ifb.macWeight + ifb.macSum;
    for (int k = 1; k < L - 1; k++) begin
      pa[k] <= pa[k-1];
      pb[k] <= pb[k-1];
    end
  end

  assign ifa.macResult = pa[L-2];
  assign ifb.macResult = pb[L-2];

  item_t qa[$];
  item_t qb[$];
  logic [31:0] dat [9];
  logic [31:0] wgt [9];
  bit just_acc = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_macData"}, ifa.macData, 0);
    chk({tag, "_macWeight"}, ifa.macWeight, 0);
    chk({tag, "_macSum"}, ifa.macSum, 0);
    chk({tag, "_outResult"}, ifa.outResult, 0);
    chk({tag, "_outValid"}, {31'd0, ifa.outValid}, 0);
    chk({tag, "_inReady"}, {31'd0, ifa.inReady}, 0);
    chk({tag, "_busy"}, {31'd0, ifa.busy}, 0);
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (ifa.busy && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (ifa.busy) chk("a_idle_timeout", {31'd0, ifa.busy}, 0);
  endtask

  task automatic send_a(input logic [31:0] d, input logic [31:0] w);
    int n = 0;
    ifa.inValid  = 1'b1;
    ifa.inData   = d;
    ifa.inWeight = w;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && just_acc)
        chk("a_ready_in_wait", {31'd0, ifa.inReady}, 0);
    end while (!ifa.inReady && n < 100);
    if (!ifa.inReady) chk("a_accept_timeout", {31'd0, ifa.inReady}, 1);
    @(posedge clk); #1;
    ifa.inValid = 1'b0;
    just_acc = 1'b1;
  endtask

  task automatic run_a(input logic [31:0] b, input int lat, input int stall,
                       input int gapi, input bit rgap, input bit sw,
                       input bit sd);
    item_t it;
    int n;
    wait_idle_a();
    it.res = b;
    for (int i = 0; i < 9; i++) it.res = it.res + dat[i] * wgt[i];
    it.lat = lat;
    it.stall = stall;
    it.t0 = cyc;
    qa.push_back(it);
    just_acc = 1'b0;
    ifa.start = 1'b1;
    ifa.bias  = b;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (rgap) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
      end
      if (i == gapi) begin
        // three LOAD cycles with nothing offered
        n = 0;
        do begin
          @(negedge clk); n++;
        end while (!ifa.inReady && n < 100);
        chk("a_gap_ready", {31'd0, ifa.inReady}, 1);
        repeat (2) begin
          @(posedge clk); @(negedge clk);
          chk("a_gap_ready", {31'd0, ifa.inReady}, 1);
        end
        @(posedge clk); #1;
        just_acc = 1'b0;
      end
      send_a(dat[i], wgt[i]);
      if (sw && i == 1) begin
        ifa.start = 1'b1;
        ifa.bias  = 32'd1000;
        @(posedge clk); #1;
        ifa.start = 1'b0;
      end
    end
    if (sd) begin
      n = 0;
      do begin
        @(negedge clk); n++;
      end while (!ifa.outValid && n < 100);
      ifa.start = 1'b1;
      ifa.bias  = 32'd1000;
      @(negedge clk);
      ifa.start = 1'b0;
    end
  endtask

  task automatic run_b(input logic [31:0] b, input logic [31:0] d,
                       input logic [31:0] w, input int lat);
    item_t it;
    int n = 0;
    while (ifb.busy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    it.res = b + d * w;
    it.lat = lat;
    it.stall = 0;
    it.t0 = cyc;
    qb.push_back(it);
    ifb.start = 1'b1;
    ifb.bias  = b;
    @(posedge clk); #1;
    ifb.start    = 1'b0;
    ifb.inValid  = 1'b1;
    ifb.inData   = d;
    ifb.inWeight = w;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!ifb.inReady && n < 100);
    if (!ifb.inReady) chk("b_accept_timeout", {31'd0, ifb.inReady}, 1);
    @(posedge clk); #1;
    ifb.inValid = 1'b0;
  endtask

  // monitor A
  bit    in_a = 1'b0;
  bit    ack_a = 1'b0;
  int    hold_a = 0;
  item_t cur_a;

  always @(negedge clk) begin
    if (ack_a) begin
      ack_a = 1'b0;
      in_a  = 1'b0;
      ifa.outReady = 1'b0;
      chk("a_ack_valid", {31'd0, ifa.outValid}, 0);
      chk("a_ack_idle", {31'd0, ifa.busy}, 0);
    end else if (ifa.outValid) begin
      if (!in_a) begin
        in_a = 1'b1;
        hold_a = 0;
        if (qa.size() == 0) begin
          chk("a_spurious_valid", {31'd0, ifa.outValid}, 0);
        end else begin
          cur_a = qa.pop_front();
          chk("a_result", ifa.outResult, cur_a.res);
          if (cur_a.lat >= 0)
            chk("a_latency", cyc - cur_a.t0, cur_a.lat);
          hold_a = cur_a.stall;
        end
      end else begin
        chk("a_hold_result", ifa.outResult, cur_a.res);
      end
      if (hold_a == 0) begin
        ifa.outReady = 1'b1;
        ack_a = 1'b1;
      end else begin
        hold_a--;
      end
    end else if (in_a) begin
      chk("a_valid_dropped", {31'd0, ifa.outValid}, 1);
      in_a = 1'b0;
    end
  end

  // monitor B
  bit    ack_b = 1'b0;
  item_t cur_b;

  always @(negedge clk) begin
    if (ack_b) begin
      ack_b = 1'b0;
      ifb.outReady = 1'b0;
      chk("b_ack_valid", {31'd0, ifb.outValid}, 0);
      chk("b_ack_idle", {31'd0, ifb.busy}, 0);
    end else if (ifb.outValid) begin
      if (qb.size() == 0) begin
        chk("b_spurious_valid", {31'd0, ifb.outValid}, 0);
      end else begin
        cur_b = qb.pop_front();
        chk("b_result", ifb.outResult, cur_b.res);
        if (cur_b.lat >= 0)
          chk("b_latency", cyc - cur_b.t0, cur_b.lat);
      end
      ifb.outReady = 1'b1;
      ack_b = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifa.start = 0; ifa.bias = 0; ifa.inValid = 0;
    ifa.inData = 0; ifa.inWeight = 0; ifa.outReady = 0;
    ifb.start = 0; ifb.bias = 0; ifb.inValid = 0;
    ifb.inData = 0; ifb.inWeight = 0; ifb.outReady = 0;
    for (int k = 0; k < L - 1; k++) begin
      pa[k] = 0;
      pb[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk("rst0");
    chk("rst0_b_busy", {31'd0, ifb.busy}, 0);
    chk("rst0_b_outValid", {31'd0, ifb.outValid}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 5 + 2*(0+..+8) = 77
    for (int i = 0; i < 9; i++) begin
      dat[i] = i;
      wgt[i] = 2;
    end
    run_a(5, 46, 0, -1, 0, 0, 0);
    run_a(5, 49, 0, 4, 0, 0, 0);
    run_a(5, 46, 10, -1, 0, 0, 0);
    run_a(5, 46, 10, -1, 0, 1, 1);

    // abandon after three pairs
    wait_idle_a();
    for (int i = 0; i < 9; i++) begin
      dat[i] = i + 3;
      wgt[i] = 7;
    end
    ifa.start = 1'b1;
    ifa.bias  = 5;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    just_acc = 1'b0;
    for (int i = 0; i < 3; i++) send_a(dat[i], wgt[i]);
    rst = 1'b1;
    #1;
    rst_chk("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 9; i++) begin
      dat[i] = 1;
      wgt[i] = 1;
    end
    just_acc = 1'b0;
    run_a(0, 46, 0, -1, 0, 0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 9; i++) begin
        dat[i] = $urandom_range(0, 1000);
        wgt[i] = $urandom();
      end
      run_a($urandom(), -1, $urandom_range(0, 3), -1, 1, 0, 0);
    end

    run_b(3, 4, 5, 6);
    for (int t = 0; t < 4; t++)
      run_b($urandom(), $urandom(), $urandom(), 6);

    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || ifa.busy || ifb.busy)
           && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    repeat (3) @(posedge clk);
    chk("a_drained", qa.size(), 0);
    chk("b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
